servo_ramp_ctrl: RTL
====================

# servo_ramp_ctrl

Slew-limited position sequencer for the 16-bit PWM servo channel. Accepts target-position commands over a valid/ready handshake and steps the servo's PWM high-time setting toward the target by a programmable amount once per PWM frame, so the servo never receives a large instantaneous jump. Drives the channel's `setPwm` input, holds the final value for a settle period, then reports completion. One instance per servo channel, between the host/register logic and the PWM generator.

## Interface
Parameters:
- `RESET_POS`, 16'h0001: `set_pwm` value after reset.
- `POS_MIN`, 16'h0001: lower clamp bound when clamping is compiled in.
- `POS_MAX`, 16'hFFFF: upper clamp bound when clamping is compiled in.
- `SETTLE_FRAMES`, 8'd4: frames held at target before `done`. Width is 8 bits.

Ports:
- `clk`  in  1: system clock.
- `resetb`  in  1: reset. Asynchronous, active-low.
- `frame_tick`  in  1: one-cycle pulse per PWM frame, from the PWM generator's frame boundary.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: command accepted when `cmd_valid & cmd_ready` at a rising `clk` edge.
- `cmd_pos`  in  16: target PWM high-time count.
- `cmd_step`  in  16: maximum change per frame. A value of 0 means jump directly to the target.
- `set_pwm`  out  16: PWM high-time setting, registered.
- `busy`  out  1: high in RAMP or SETTLE.
- `done`  out  1: one-cycle pulse when settle completes.

## Operation
- State register `state` has three states: IDLE, RAMP, SETTLE. Internal registers are `target[15:0]`, `step[15:0]`, and `settle_cnt[7:0]`.
- Reset values:
  - `state` = IDLE.
  - `set_pwm` = RESET_POS.
  - `target` = RESET_POS.
  - `step` = 0.
  - `settle_cnt` = 0.
  - `done` = 0.
  - `busy` = 0.
  - `cmd_ready` = 1.
- `cmd_ready` is 1 in IDLE and RAMP, and 0 in SETTLE.
- Accepting a command loads `target` and `step`.
  - From IDLE, the next state is RAMP.
  - In RAMP, the new values replace the old ones (retarget) and the state stays RAMP.
- RAMP, on each `frame_tick`, with `diff` = |target − set_pwm| computed at 17 bits with no wrap:
  - If `step` == 0 or `diff` ≤ `step`: `set_pwm` ← `target`. If SETTLE_FRAMES == 0, go to IDLE and pulse `done`. Otherwise go to SETTLE with `settle_cnt` ← 0.
  - Else: `set_pwm` ← `set_pwm` ± `step`, moving toward `target`. The result never overshoots and never wraps.
- SETTLE:
  - Each `frame_tick` increments `settle_cnt`.
  - When the incremented value equals SETTLE_FRAMES, go to IDLE and assert `done` for one cycle.
  - `cmd_valid` is ignored in SETTLE; the command stays pending until IDLE.
- A command to the current `set_pwm` value is still a full transaction: RAMP, then SETTLE, then `done`.
- `busy` = (state != IDLE), registered with the state.

## Timing
- Acceptance at edge N puts the block in RAMP from edge N onward. The first `set_pwm` change happens at the edge that samples the first `frame_tick` after N.
- `set_pwm` changes only on edges where `frame_tick` = 1. This guarantees the PWM generator latches a stable value at its frame start.
- Command acceptance and `frame_tick` on the same edge in RAMP: the step that edge uses the old `target`/`step`. The new values apply from the next tick.
- Command acceptance and `frame_tick` on the same edge in IDLE: the tick is ignored. Ramping starts on the next tick.
- `done` rises on the edge that leaves SETTLE, lasts exactly one cycle, and coincides with `cmd_ready` returning to 1.
- `resetb` low asserts all reset values asynchronously at any point, including mid-ramp. No `done` pulse is produced for an aborted transaction.
- Latency to settle from acceptance is ceil(diff/step) + SETTLE_FRAMES frame ticks.

## Configuration
- Macro: `SERVO_RAMP_CLAMP_EN`.
- Defined: `cmd_pos` is clamped to [POS_MIN, POS_MAX] before loading into `target`, so a value below POS_MIN loads POS_MIN. This protects the servo's mechanical end stops.
- Undefined: `cmd_pos` loads unmodified. POS_MIN and POS_MAX are unused.

## Test plan
- Reset, then a command with pos=0x0100 and step=0x0040, default parameters:
  - `set_pwm` sequence 0x0041, 0x0081, 0x00C1, 0x0100 on four consecutive ticks.
  - `done` pulses 4 ticks later.
  - `busy` is high throughout.
- `set_pwm`=0x0100, command pos=0x0010, step=0x0050: sequence 0x00B0, 0x0060, 0x0010 with no underflow.
- Retarget mid-ramp: while ramping to 0x1000 with step 0x0100, accept pos=0x0200 on the same cycle as a tick.
  - That tick still steps toward 0x1000.
  - Subsequent ticks move toward 0x0200.
- step=0, pos=0x8000: `set_pwm` = 0x8000 on the first tick.
  - During SETTLE, `cmd_ready`=0 and a pending command is not accepted until the `done` cycle.
- Assert `resetb` low asynchronously mid-ramp (between clock edges): `set_pwm`=0x0001, `busy`=0, `cmd_ready`=1 immediately, and no `done` pulse.
- With `SERVO_RAMP_CLAMP_EN` and POS_MIN=0x0100:
  - Command pos=0x0000 settles at 0x0100.
  - Without the macro, it settles at 0x0000.

Source files
------------

// File: rtl/servo_ramp_ctrl_if.sv
// Command channel between host/register logic and one servo ramp controller.
// The host drives valid/pos/step; the controller answers with ready.
interface servo_ramp_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_pos;
    logic [15:0] cmd_step;

    modport master (
        output cmd_valid,
        output cmd_pos,
        output cmd_step,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_pos,
        input  cmd_step,
        output cmd_ready
    );
endinterface

// File: rtl/servo_ramp_ctrl.sv
// Slew-limited servo position sequencer: steps set_pwm toward a commanded target once per frame.
// Optional macro SERVO_RAMP_CLAMP_EN clamps incoming targets to [POS_MIN, POS_MAX].
module servo_ramp_ctrl #(
    parameter logic [15:0] RESET_POS     = 16'h0001,
    parameter logic [15:0] POS_MIN       = 16'h0001,
    parameter logic [15:0] POS_MAX       = 16'hFFFF,
    parameter logic [7:0]  SETTLE_FRAMES = 8'd4
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  frame_tick,
    servo_ramp_ctrl_if.slave      cmd,
    output logic [15:0]           set_pwm,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        SETTLE = 2'd2
    } state_t;

`ifdef SERVO_RAMP_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
`else
    localparam bit CLAMP_ON = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [15:0] set_pwm_q, set_pwm_d;
    logic [15:0] target_q, target_d;
    logic [15:0] step_q, step_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic        accept;
    logic [15:0] load_pos;
    logic        ramp_up;
    logic [16:0] diff_mag;
    logic [7:0]  settle_inc;

    function automatic logic [15:0] clamp_pos(input logic [15:0] p);
        if (p < POS_MIN) begin
            return POS_MIN;
        end
        if (p > POS_MAX) begin
            return POS_MAX;
        end
        return p;
    endfunction

    // Commands are held off while settling so the final value stays put for the whole period.
    assign cmd.cmd_ready = (state_q != SETTLE);
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign load_pos      = CLAMP_ON ? clamp_pos(cmd.cmd_pos) : cmd.cmd_pos;

    // Distance is taken at 17 bits so neither direction can wrap.
    assign ramp_up    = (target_q > set_pwm_q);
    assign diff_mag   = ramp_up ? ({1'b0, target_q} - {1'b0, set_pwm_q})
                                : ({1'b0, set_pwm_q} - {1'b0, target_q});
    assign settle_inc = settle_cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        set_pwm_d    = set_pwm_q;
        target_d     = target_q;
        step_d       = step_q;
        settle_cnt_d = settle_cnt_q;
        done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    target_d = load_pos;
                    step_d   = cmd.cmd_step;
                    state_d  = RAMP;
                end
            end

            RAMP: begin
                if (frame_tick) begin
                    if ((step_q == 16'd0) || (diff_mag <= {1'b0, step_q})) begin
                        set_pwm_d = target_q;
                        if (SETTLE_FRAMES == 8'd0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d      = SETTLE;
                            settle_cnt_d = 8'd0;
                        end
                    end else if (ramp_up) begin
                        set_pwm_d = set_pwm_q + step_q;
                    end else begin
                        set_pwm_d = set_pwm_q - step_q;
                    end
                end
                // A retarget on a tick edge lets the tick use the old target; the new one takes over after.
                if (accept) begin
                    target_d = load_pos;
                    step_d   = cmd.cmd_step;
                    state_d  = RAMP;
                    done_d   = 1'b0;
                end
            end

            SETTLE: begin
                if (frame_tick) begin
                    if (settle_inc == SETTLE_FRAMES) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        settle_cnt_d = settle_inc;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q      <= IDLE;
            set_pwm_q    <= RESET_POS;
            target_q     <= RESET_POS;
            step_q       <= 16'd0;
            settle_cnt_q <= 8'd0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            set_pwm_q    <= set_pwm_d;
            target_q     <= target_d;
            step_q       <= step_d;
            settle_cnt_q <= settle_cnt_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign set_pwm = set_pwm_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
